// File: rtl/hwpe_ctrl_uloop_stream.sv
// Nested-loop offset streamer: walks NB_LOOPS nested counters and emits one
// beat of per-channel offsets per valid/ready handshake.
module hwpe_ctrl_uloop_stream #(
    parameter int unsigned NB_LOOPS  = 6,
    parameter int unsigned NB_CH     = 4,
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic                                            clear_i,
    input  logic                                            start_i,
    input  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]              range_i,
    input  logic [NB_LOOPS-1:0][NB_CH-1:0][REG_WIDTH-1:0]   stride_i,
    input  logic [NB_CH-1:0][REG_WIDTH-1:0]                 base_i,
    output logic                                            valid_o,
    input  logic                                            ready_i,
    output logic [NB_CH-1:0][REG_WIDTH-1:0]                 offs_o,
    output logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]              idx_o,
    output logic [NB_LOOPS-1:0]                             last_o,
    output logic                                            busy_o,
    output logic                                            done_o
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e                                          state_q, state_d;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]              range_q, range_d;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]              idx_q, idx_d;
    logic [NB_LOOPS-1:0][NB_CH-1:0][REG_WIDTH-1:0]   stride_q, stride_d;
    logic [NB_LOOPS-1:0][NB_CH-1:0][REG_WIDTH-1:0]   lvl_base_q, lvl_base_d;
    logic                                            done_q, done_d;

    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]              rng_m1;
    logic [NB_LOOPS-1:0]                             last;
    logic [NB_LOOPS-1:0]                             sel;
    logic [NB_LOOPS-1:0]                             below;
    logic [NB_CH-1:0][REG_WIDTH-1:0]                 inc_base;
    logic                                            acc;
    logic                                            carry;

    // A latched range of 0 behaves as a single iteration.
    always_comb begin
        acc    = 1'b1;
        rng_m1 = '0;
        last   = '0;
        for (int unsigned l = 0; l < NB_LOOPS; l++) begin
            rng_m1[l] = (range_q[l] == '0) ? '0 : range_q[l] - CNT_WIDTH'(1);
            acc       = acc & (idx_q[l] == rng_m1[l]);
            last[l]   = acc;
        end
    end

    // sel marks the lowest level that still advances; below marks the levels
    // underneath it, which wrap to 0 and inherit the advanced base.
    always_comb begin
        carry    = 1'b1;
        sel      = '0;
        below    = '0;
        inc_base = '0;
        for (int unsigned l = 0; l < NB_LOOPS; l++) begin
            if (carry) begin
                if (idx_q[l] != rng_m1[l]) begin
                    sel[l] = 1'b1;
                    carry  = 1'b0;
                end else begin
                    below[l] = 1'b1;
                end
            end
        end
        for (int unsigned l = 0; l < NB_LOOPS; l++) begin
            if (sel[l]) begin
                for (int unsigned c = 0; c < NB_CH; c++) begin
                    inc_base[c] = lvl_base_q[l][c] + stride_q[l][c];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        range_d    = range_q;
        stride_d   = stride_q;
        idx_d      = idx_q;
        lvl_base_d = lvl_base_q;
        done_d     = 1'b0;

        if (clear_i) begin
            state_d    = IDLE;
            range_d    = '0;
            stride_d   = '0;
            idx_d      = '0;
            lvl_base_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        range_d  = range_i;
                        stride_d = stride_i;
                        idx_d    = '0;
                        for (int unsigned l = 0; l < NB_LOOPS; l++) begin
                            lvl_base_d[l] = base_i;
                        end
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (ready_i) begin
                        if (last[NB_LOOPS-1]) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            for (int unsigned l = 0; l < NB_LOOPS; l++) begin
                                if (sel[l]) begin
                                    idx_d[l]      = idx_q[l] + CNT_WIDTH'(1);
                                    lvl_base_d[l] = inc_base;
                                end else if (below[l]) begin
                                    idx_d[l]      = '0;
                                    lvl_base_d[l] = inc_base;
                                end
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            range_q    <= '0;
            stride_q   <= '0;
            idx_q      <= '0;
            lvl_base_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            range_q    <= range_d;
            stride_q   <= stride_d;
            idx_q      <= idx_d;
            lvl_base_q <= lvl_base_d;
            done_q     <= done_d;
        end
    end

    assign valid_o = (state_q == RUN);
    assign busy_o  = (state_q == RUN);
    assign offs_o  = lvl_base_q[0];
    assign idx_o   = idx_q;
    assign last_o  = (state_q == RUN) ? last : '0;
    assign done_o  = done_q;

endmodule

// File: tb/tb_hwpe_ctrl_uloop_stream.sv
// Self-checking bench for hwpe_ctrl_uloop_stream: expected beats come from a
// mixed-radix decomposition of the beat number.
module tb_hwpe_ctrl_uloop_stream;

    localparam int unsigned NL = 3;
    localparam int unsigned NC = 2;
    localparam int unsigned RW = 32;
    localparam int unsigned CW = 16;

    logic                          clk_i = 1'b0;
    logic                          rst_ni, clear_i, start_i, ready_i;
    logic                          valid_o, busy_o, done_o;
    logic [NL-1:0][CW-1:0]         range_i, idx_o;
    logic [NL-1:0][NC-1:0][RW-1:0] stride_i;
    logic [NC-1:0][RW-1:0]         base_i, offs_o;
    logic [NL-1:0]                 last_o;

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] cfg_range  [NL];
    logic [RW-1:0] cfg_stride [NL][NC];
    logic [RW-1:0] cfg_base   [NC];

    hwpe_ctrl_uloop_stream #(
        .NB_LOOPS (NL),
        .NB_CH    (NC),
        .REG_WIDTH(RW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .start_i (start_i),
        .range_i (range_i),
        .stride_i(stride_i),
        .base_i  (base_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .offs_o  (offs_o),
        .idx_o   (idx_o),
        .last_o  (last_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int eff(input int l);
        return (cfg_range[l] == 0) ? 1 : int'(cfg_range[l]);
    endfunction

    function automatic int n_beats();
        int p = 1;
        for (int l = 0; l < NL; l++) p = p * eff(l);
        return p;
    endfunction

    // Beat n has loop indices given by n written in mixed radix (level 0 fastest).
    task automatic model(input int beat, output logic [NC-1:0][RW-1:0] eo,
                         output logic [NL-1:0][CW-1:0] ei, output logic [NL-1:0] el);
        int rem = beat;
        int iv;
        bit all = 1'b1;
        for (int l = 0; l < NL; l++) begin
            iv    = rem % eff(l);
            rem   = rem / eff(l);
            ei[l] = CW'(iv);
            all   = all && (iv == eff(l) - 1);
            el[l] = all;
        end
        for (int c = 0; c < NC; c++) begin
            eo[c] = cfg_base[c];
            for (int l = 0; l < NL; l++) eo[c] = eo[c] + RW'(ei[l]) * cfg_stride[l][c];
        end
    endtask

    task automatic drive_cfg();
        for (int l = 0; l < NL; l++) begin
            range_i[l] = cfg_range[l];
            for (int c = 0; c < NC; c++) stride_i[l][c] = cfg_stride[l][c];
        end
        for (int c = 0; c < NC; c++) base_i[c] = cfg_base[c];
    endtask

    task automatic rand_cfg(input int max_range);
        for (int l = 0; l < NL; l++) begin
            cfg_range[l] = CW'($urandom_range(0, max_range));
            for (int c = 0; c < NC; c++) cfg_stride[l][c] = $urandom;
        end
        for (int c = 0; c < NC; c++) cfg_base[c] = $urandom;
    endtask

    task automatic set_033_cfg();
        rand_cfg(0);
        cfg_range[0] = 3; cfg_range[1] = 2; cfg_range[2] = 1;
        cfg_base[0] = 32'h100;
        cfg_stride[0][0] = 32'h4;
        cfg_stride[1][0] = 32'h40;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;
        range_i = '0; stride_i = '0; base_i = '0;
        #3;
        checks++;
        if ({valid_o, busy_o, done_o} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000", {valid_o, busy_o, done_o});
        end
        checks++;
        if (offs_o !== '0 || idx_o !== '0 || last_o !== '0) begin
            errors++; $display("FAIL reset_data: offs %h idx %h last %b want zeros", offs_o, idx_o, last_o);
        end
        @(negedge clk_i); rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    // Runs one full stream from cfg_*; optional forced stall and input disturbance.
    task automatic test_stream(input string name, input int stall_at, input int stall_len,
                               input bit rand_ready, input bit disturb);
        logic [NC-1:0][RW-1:0] eo;
        logic [NL-1:0][CW-1:0] ei;
        logic [NL-1:0]         el;
        int total   = n_beats();
        int beat    = 0;
        int stalled = 0;
        int guard   = 0;
        @(negedge clk_i);
        drive_cfg();
        start_i = 1'b1; ready_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        while (beat < total && guard < 2000) begin
            guard++;
            if (beat == stall_at && stalled < stall_len) begin
                ready_i = 1'b0; stalled++;
            end else if (rand_ready) ready_i = ($urandom_range(0, 2) != 0);
            else ready_i = 1'b1;
            if (disturb) begin
                start_i  = ($urandom_range(0, 3) == 0);
                base_i   = {$urandom, $urandom};
                range_i  = {CW'($urandom), CW'($urandom), CW'($urandom)};
                stride_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
            model(beat, eo, ei, el);
            checks++;
            if (valid_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0) begin
                errors++;
                $display("FAIL %s_ctrl beat %0d: valid %b busy %b done %b want 1 1 0",
                         name, beat, valid_o, busy_o, done_o);
            end
            checks++;
            if (offs_o !== eo) begin
                errors++; $display("FAIL %s_offs beat %0d: got %h want %h", name, beat, offs_o, eo);
            end
            checks++;
            if (idx_o !== ei || last_o !== el) begin
                errors++;
                $display("FAIL %s_idx beat %0d: idx %h last %b want idx %h last %b",
                         name, beat, idx_o, last_o, ei, el);
            end
            if (ready_i) beat++;
            @(negedge clk_i);
        end
        start_i = 1'b0; ready_i = 1'b0;
        checks++;
        if (guard >= 2000) begin
            errors++; $display("FAIL %s_timeout: beats %0d want %0d", name, beat, total);
        end
        model(total - 1, eo, ei, el);
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: valid %b busy %b done %b want 0 0 1", name, valid_o, busy_o, done_o);
        end
        checks++;
        if (offs_o !== eo || idx_o !== ei) begin
            errors++; $display("FAIL %s_hold: offs %h idx %h want %h %h", name, offs_o, idx_o, eo, ei);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL %s_done_pulse: done %b valid %b want 0 0", name, done_o, valid_o);
        end
    endtask

    task automatic test_clear();
        set_033_cfg();
        @(negedge clk_i);
        drive_cfg(); start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        clear_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;
        checks++;
        if ({valid_o, busy_o, done_o} !== 3'b000) begin
            errors++; $display("FAIL clear_ctrl: got %b want 000", {valid_o, busy_o, done_o});
        end
        checks++;
        if (offs_o !== '0 || idx_o !== '0 || last_o !== '0) begin
            errors++; $display("FAIL clear_data: offs %h idx %h last %b want zeros", offs_o, idx_o, last_o);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL clear_nodone: done %b valid %b want 0 0", done_o, valid_o);
        end
    endtask

    task automatic test_async_reset();
        rand_cfg(3);
        cfg_range[0] = 4;
        @(negedge clk_i);
        drive_cfg(); start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({valid_o, busy_o, done_o} !== 3'b000 || offs_o !== '0 || idx_o !== '0 || last_o !== '0) begin
            errors++;
            $display("FAIL async_reset: v%b b%b d%b offs %h idx %h last %b want zeros",
                     valid_o, busy_o, done_o, offs_o, idx_o, last_o);
        end
        ready_i = 1'b0;
        @(negedge clk_i); rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL async_reset_idle: valid %b want 0", valid_o);
        end
    endtask

    initial begin
        test_reset();

        set_033_cfg();
        test_stream("basic", -1, 0, 1'b0, 1'b0);

        set_033_cfg();
        test_stream("stall", 2, 3, 1'b0, 1'b0);

        rand_cfg(0);
        test_stream("range0", -1, 0, 1'b0, 1'b0);

        rand_cfg(0);
        cfg_range[0] = 2;
        cfg_base[0] = 32'hFFFF_FFFC;
        cfg_stride[0][0] = 32'h8;
        test_stream("wrap", -1, 0, 1'b0, 1'b0);

        test_clear();
        set_033_cfg();
        test_stream("restart", -1, 0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rand_cfg(3);
            test_stream("random", -1, 0, 1'b1, 1'b1);
        end

        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
